fb_writer: RTL



---
 rtl/fb_writer.sv | 95 +++++++++
 1 files changed

// File: rtl/fb_writer.sv
// fb_writer: final stage of the ray-tracing pipeline. Accepts the raster-ordered
// shaded pixel stream, replaces misses with a per-frame background colour,
// packs RGB888 into RGB565 and writes each pixel to its linear framebuffer
// address. Frames are sequenced by a start pulse and hit statistics are kept.
module fb_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 360,
    parameter int ADDR_W = 18
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [15:0]       bg_color,
    input  logic [24:0]       pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    output logic              fb_we,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] hit_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pix_idx;
    logic [ADDR_W-1:0] hit_run;
    logic [15:0]       bg_lat;

    logic              accept;
    logic              beat_hit;
    logic [15:0]       beat_rgb565;

    // RGB888 -> RGB565 by truncating the low bits of each channel
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

    // Upstream may only hand over beats while a frame is running
    assign pixel_axis_tready = (state == RUN);
    assign busy              = (state == RUN);
    assign accept            = pixel_axis_tvalid & pixel_axis_tready;
    assign beat_hit          = pixel_axis_tdata[24];
    assign beat_rgb565       = rgb888_to_565(pixel_axis_tdata[23:0]);

    // Frame sequencer with registered write port and statistics outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            pix_idx    <= '0;
            hit_run    <= '0;
            bg_lat     <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            hit_count  <= '0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bg_lat  <= bg_color;
                        pix_idx <= '0;
                        hit_run <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here: a running
                    // frame is never restarted, even on its last beat
                    if (accept) begin
                        fb_we   <= 1'b1;
                        fb_addr <= pix_idx;
                        fb_data <= beat_hit ? beat_rgb565 : bg_lat;
                        pix_idx <= pix_idx + 1'b1;
                        hit_run <= hit_run + ADDR_W'(beat_hit);
                        if (pix_idx == LAST_IDX) begin
                            state      <= IDLE;
                            hit_count  <= hit_run + ADDR_W'(beat_hit);
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
